// File: rtl/v_pkg.sv
// Shared definitions for the vector store unit.
//   VLEN              : bits per vector register
//   VLSU_VSE*/VSSE*   : store opcodes (bit 2 = strided, bits 1:0 = log2 of element bytes)
//   vsu_state_t       : store FSM states
//   sew_decode        : opcode -> log2(element bytes)
//   op_valid          : opcode legality
package v_pkg;

  localparam int unsigned VLEN = 128;

  localparam logic [3:0] VLSU_VSE8   = 4'h0;
  localparam logic [3:0] VLSU_VSE16  = 4'h1;
  localparam logic [3:0] VLSU_VSE32  = 4'h2;
  localparam logic [3:0] VLSU_VSSE8  = 4'h4;
  localparam logic [3:0] VLSU_VSSE16 = 4'h5;
  localparam logic [3:0] VLSU_VSSE32 = 4'h6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    DONE  = 2'd2
  } vsu_state_t;

  // 0 = 8-bit, 1 = 16-bit, 2 = 32-bit elements
  function automatic logic [1:0] sew_decode(input logic [3:0] op);
    return op[1:0];
  endfunction

  function automatic logic op_valid(input logic [3:0] op);
    return (op[3] == 1'b0) && (op[1:0] != 2'd3);
  endfunction

  function automatic logic op_strided(input logic [3:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/v_store_lane.sv
// One memory lane of the vector store unit (purely combinational).
// Ports:
//   elem     : element index carried by this lane in the beat
//   base     : byte address of element 0
//   stride   : signed byte stride (used when strided = 1)
//   strided  : strided addressing select
//   sew      : log2 of element bytes (0/1/2)
//   group    : register group data, element e at [e*SEW +: SEW]
//   addr     : lane byte address
//   data     : element zero-extended and shifted to byte lane addr[1:0]
//   be       : byte enables, truncated to 4 bits
//   misalign : element not naturally aligned for its size
module v_store_lane #(
  parameter int unsigned VLEN = 128
) (
  input  logic [5:0]          elem,
  input  logic [31:0]         base,
  input  logic [31:0]         stride,
  input  logic                strided,
  input  logic [1:0]          sew,
  input  logic [4*VLEN-1:0]   group,
  output logic [31:0]         addr,
  output logic [31:0]         data,
  output logic [3:0]          be,
  output logic                misalign
);

  logic [31:0] offset;
  logic [31:0] elem_val;
  logic [3:0]  be_base;

  always_comb begin
    offset   = strided ? (32'(elem) * stride) : (32'(elem) << sew);
    addr     = base + offset;
    elem_val = '0;
    be_base  = 4'b1111;
    case (sew)
      2'd0: begin
        elem_val = {24'b0, group[{elem, 3'b000} +: 8]};
        be_base  = 4'b0001;
      end
      2'd1: begin
        elem_val = {16'b0, group[{elem[4:0], 4'b0000} +: 16]};
        be_base  = 4'b0011;
      end
      default: begin
        elem_val = group[{elem[3:0], 5'b00000} +: 32];
        be_base  = 4'b1111;
      end
    endcase
    // Bytes pushed past bit 31 fall off; the shifted enables drop them too.
    data     = elem_val << {addr[1:0], 3'b000};
    be       = be_base << addr[1:0];
    misalign = ((sew == 2'd1) && addr[0]) || ((sew == 2'd2) && (addr[1:0] != 2'b00));
  end

endmodule

// File: rtl/v_store_unit.sv
// Vector store unit: streams up to 512 bits of register group data to a 4-lane,
// 32-bit-per-lane memory write port, 4 elements per beat, under mem_we/mem_ready.
// Optional feature macro: VSU_MISALIGN_CHECK_EN (disables misaligned lanes and
// reports them on s_err at completion).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   s_start             : start request (honoured only when idle)
//   vlsu_op, lmul, vl   : opcode, register grouping, element count
//   s_base_addr         : byte address of element 0
//   s_stride            : signed byte stride for strided ops
//   s_data_in           : register group data
//   mem_ready           : memory accepts the presented beat
//   s_busy, s_done      : operation in progress, one-cycle completion pulse
//   s_err               : valid with s_done; bad opcode or misaligned lane
//   mem_we, mem_lane_en : beat valid, per-lane enables
//   mem_addrN/dataN/beN : per-lane address, data and byte enables
module v_store_unit #(
  parameter int unsigned VLEN   = v_pkg::VLEN,
  parameter int unsigned NLANES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_start,
  input  logic [3:0]          vlsu_op,
  input  logic [2:0]          lmul,
  input  logic [6:0]          vl,
  input  logic [31:0]         s_base_addr,
  input  logic [31:0]         s_stride,
  input  logic [4*VLEN-1:0]   s_data_in,
  input  logic                mem_ready,
  output logic                s_busy,
  output logic                s_done,
  output logic                s_err,
  output logic                mem_we,
  output logic [3:0]          mem_lane_en,
  output logic [31:0]         mem_addr0,
  output logic [31:0]         mem_addr1,
  output logic [31:0]         mem_addr2,
  output logic [31:0]         mem_addr3,
  output logic [31:0]         mem_data0,
  output logic [31:0]         mem_data1,
  output logic [31:0]         mem_data2,
  output logic [31:0]         mem_data3,
  output logic [3:0]          mem_be0,
  output logic [3:0]          mem_be1,
  output logic [3:0]          mem_be2,
  output logic [3:0]          mem_be3
);

  import v_pkg::*;

  localparam int unsigned GroupW = 4 * VLEN;

  vsu_state_t state_q;

  // Operation context captured at start
  logic              strided_q;
  logic [1:0]        sew_q;
  logic [31:0]       base_q;
  logic [31:0]       stride_q;
  logic [GroupW-1:0] group_q;
  logic [6:0]        count_q;
  logic [3:0]        last_q;
  logic [3:0]        beat_q;
  logic              sticky_q;

  // Registered outputs
  logic              busy_q, done_q, err_q, we_q;
  logic [3:0]        lane_en_q;
  logic [31:0]       addr_q [NLANES];
  logic [31:0]       data_q [NLANES];
  logic [3:0]        be_q   [NLANES];

  // Start-time decode of the raw inputs
  logic       in_valid;
  logic [1:0] in_sew;
  logic [1:0] lmul_sh;
  logic [6:0] per_reg, vlmax, in_count;
  logic [3:0] in_last;

  always_comb begin
    in_valid = op_valid(vlsu_op);
    in_sew   = sew_decode(vlsu_op);
    case (lmul)
      3'b001:  lmul_sh = 2'd1;
      3'b010:  lmul_sh = 2'd2;
      default: lmul_sh = 2'd0;
    endcase
    per_reg  = 7'(VLEN / 8) >> in_sew;
    vlmax    = per_reg << lmul_sh;
    in_count = (vl < vlmax) ? vl : vlmax;
    in_last  = 4'((in_count - 7'd1) >> 2);
  end

  logic load, accept, last_accept, present;

  assign load        = (state_q == IDLE) && s_start;
  assign accept      = (state_q == STORE) && we_q && mem_ready;
  assign last_accept = accept && (beat_q == last_q);
  assign present     = (load && in_valid && (in_count != 7'd0)) || (accept && !last_accept);

  // Lanes are fed the context of the beat to be presented next, so that beat 0
  // can be registered in the same cycle the start is accepted.
  logic              src_strided;
  logic [1:0]        src_sew;
  logic [31:0]       src_base, src_stride;
  logic [GroupW-1:0] src_group;
  logic [6:0]        src_count;
  logic [3:0]        next_beat;

  always_comb begin
    src_strided = load ? op_strided(vlsu_op) : strided_q;
    src_sew     = load ? in_sew              : sew_q;
    src_base    = load ? s_base_addr         : base_q;
    src_stride  = load ? s_stride            : stride_q;
    src_group   = load ? s_data_in           : group_q;
    src_count   = load ? in_count            : count_q;
    next_beat   = load ? 4'd0                : beat_q + 4'd1;
  end

  logic [31:0]       lane_addr [NLANES];
  logic [31:0]       lane_data [NLANES];
  logic [3:0]        lane_be   [NLANES];
  logic [NLANES-1:0] lane_mis, lane_on, lane_en;
  logic              miss_any;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    v_store_lane #(
      .VLEN (VLEN)
    ) u_lane (
      .elem     ({next_beat, 2'(k)}),
      .base     (src_base),
      .stride   (src_stride),
      .strided  (src_strided),
      .sew      (src_sew),
      .group    (src_group),
      .addr     (lane_addr[k]),
      .data     (lane_data[k]),
      .be       (lane_be[k]),
      .misalign (lane_mis[k])
    );
    assign lane_on[k] = {1'b0, next_beat, 2'(k)} < src_count;
  end

`ifdef VSU_MISALIGN_CHECK_EN
  assign lane_en  = lane_on & ~lane_mis;
  assign miss_any = |(lane_on & lane_mis);
`else
  logic unused_mis;
  assign unused_mis = ^lane_mis;
  assign lane_en    = lane_on;
  assign miss_any   = 1'b0;
`endif

  // Control and context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      strided_q <= 1'b0;
      sew_q     <= 2'd0;
      base_q    <= '0;
      stride_q  <= '0;
      group_q   <= '0;
      count_q   <= '0;
      last_q    <= '0;
      beat_q    <= '0;
      sticky_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s_start) begin
            strided_q <= src_strided;
            sew_q     <= src_sew;
            base_q    <= src_base;
            stride_q  <= src_stride;
            group_q   <= src_group;
            count_q   <= src_count;
            last_q    <= in_last;
            beat_q    <= 4'd0;
            sticky_q  <= miss_any;
            if (!in_valid || (in_count == 7'd0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= !in_valid;
            end else begin
              state_q <= STORE;
              busy_q  <= 1'b1;
            end
          end
        end
        STORE: begin
          if (last_accept) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= sticky_q;
          end else if (accept) begin
            beat_q   <= next_beat;
            sticky_q <= sticky_q | miss_any;
          end
        end
        DONE: begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port: loaded when a beat is presented, cleared after the last accept;
  // otherwise held so the port stays stable while mem_ready is low.
  always_ff @(posedge clk) begin
    if (rst || last_accept) begin
      we_q      <= 1'b0;
      lane_en_q <= '0;
      for (int k = 0; k < NLANES; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
        be_q[k]   <= '0;
      end
    end else if (present) begin
      we_q      <= 1'b1;
      lane_en_q <= lane_en;
      for (int k = 0; k < NLANES; k++) begin
        addr_q[k] <= lane_addr[k];
        data_q[k] <= lane_data[k];
        be_q[k]   <= lane_en[k] ? lane_be[k] : 4'b0000;
      end
    end
  end

  assign s_busy      = busy_q;
  assign s_done      = done_q;
  assign s_err       = err_q;
  assign mem_we      = we_q;
  assign mem_lane_en = lane_en_q;
  assign mem_addr0   = addr_q[0];
  assign mem_addr1   = addr_q[1];
  assign mem_addr2   = addr_q[2];
  assign mem_addr3   = addr_q[3];
  assign mem_data0   = data_q[0];
  assign mem_data1   = data_q[1];
  assign mem_data2   = data_q[2];
  assign mem_data3   = data_q[3];
  assign mem_be0     = be_q[0];
  assign mem_be1     = be_q[1];
  assign mem_be2     = be_q[2];
  assign mem_be3     = be_q[3];

endmodule

// File: tb/tb_v_store_unit.sv
// Directed bench for v_store_unit with hand-computed expectations.
module tb_v_store_unit;

  import v_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_start;
  logic [3:0]   vlsu_op;
  logic [2:0]   lmul;
  logic [6:0]   vl;
  logic [31:0]  s_base_addr, s_stride;
  logic [511:0] s_data_in;
  logic         mem_ready;
  logic         s_busy, s_done, s_err, mem_we;
  logic [3:0]   mem_lane_en;
  logic [31:0]  mem_addr0, mem_addr1, mem_addr2, mem_addr3;
  logic [31:0]  mem_data0, mem_data1, mem_data2, mem_data3;
  logic [3:0]   mem_be0, mem_be1, mem_be2, mem_be3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  v_store_unit u_dut (
    .clk         (clk),
    .rst         (rst),
    .s_start     (s_start),
    .vlsu_op     (vlsu_op),
    .lmul        (lmul),
    .vl          (vl),
    .s_base_addr (s_base_addr),
    .s_stride    (s_stride),
    .s_data_in   (s_data_in),
    .mem_ready   (mem_ready),
    .s_busy      (s_busy),
    .s_done      (s_done),
    .s_err       (s_err),
    .mem_we      (mem_we),
    .mem_lane_en (mem_lane_en),
    .mem_addr0   (mem_addr0),
    .mem_addr1   (mem_addr1),
    .mem_addr2   (mem_addr2),
    .mem_addr3   (mem_addr3),
    .mem_data0   (mem_data0),
    .mem_data1   (mem_data1),
    .mem_data2   (mem_data2),
    .mem_data3   (mem_data3),
    .mem_be0     (mem_be0),
    .mem_be1     (mem_be1),
    .mem_be2     (mem_be2),
    .mem_be3     (mem_be3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse s_start for one edge; returns at the sample point of cycle T+1.
  task automatic start_op(input logic [3:0] op, input logic [2:0] lm, input logic [6:0] n,
                          input logic [31:0] base, input logic [31:0] stride,
                          input logic [511:0] grp);
    vlsu_op     = op;
    lmul        = lm;
    vl          = n;
    s_base_addr = base;
    s_stride    = stride;
    s_data_in   = grp;
    s_start     = 1'b1;
    step();
    s_start     = 1'b0;
  endtask

  logic [511:0] grp;
  int           beats, accepts, done_at, last_acc, sdone_cnt;
  logic         pat [8];
  logic         prev_rdy, prev_we;
  logic [31:0]  prev_addr0, prev_data0;
  logic [3:0]   prev_en;

  initial begin
    rst = 1'b1; s_start = 1'b0; vlsu_op = '0; lmul = '0; vl = '0;
    s_base_addr = '0; s_stride = '0; s_data_in = '0; mem_ready = 1'b1;
    step();
    step();
    check("rst_we", mem_we, 0);
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_err", s_err, 0);
    check("rst_en", mem_lane_en, 0);
    check("rst_addr0", mem_addr0, 0);
    rst = 1'b0;
    step();

    // VSE32, one beat
    grp = '0;
    grp[31:0] = 32'h11111111; grp[63:32] = 32'h22222222;
    grp[95:64] = 32'h33333333; grp[127:96] = 32'h44444444;
    start_op(VLSU_VSE32, 3'b000, 7'd4, 32'h100, 32'h0, grp);
    check("vse32_busy", s_busy, 1);
    check("vse32_we", mem_we, 1);
    check("vse32_en", mem_lane_en, 4'b1111);
    check("vse32_addr0", mem_addr0, 32'h100);
    check("vse32_addr1", mem_addr1, 32'h104);
    check("vse32_addr2", mem_addr2, 32'h108);
    check("vse32_addr3", mem_addr3, 32'h10C);
    check("vse32_data0", mem_data0, 32'h11111111);
    check("vse32_data3", mem_data3, 32'h44444444);
    check("vse32_be", {mem_be3, mem_be2, mem_be1, mem_be0}, 16'hFFFF);
    check("vse32_done_early", s_done, 0);
    step();
    check("vse32_done", s_done, 1);
    check("vse32_done_busy", s_busy, 0);
    check("vse32_done_we", mem_we, 0);
    check("vse32_done_err", s_err, 0);
    step();
    check("vse32_done_pulse", s_done, 0);

    // VSE8, LMUL4, vl=64: 16 beats
    grp = '0;
    for (int e = 0; e < 64; e++) grp[e*8 +: 8] = 8'(e + 16);
    start_op(VLSU_VSE8, 3'b010, 7'd64, 32'h200, 32'h0, grp);
    beats = 0; done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      if (mem_we) begin
        if (beats == 3) begin
          check("vse8_b3_en", mem_lane_en, 4'b1111);
          check("vse8_b3_addr2", mem_addr2, 32'h20E);
          check("vse8_b3_be2", mem_be2, 4'b0100);
          check("vse8_b3_data2", mem_data2, 32'h001E0000);
        end
        if (beats == 15) begin
          check("vse8_b15_addr3", mem_addr3, 32'h23F);
          check("vse8_b15_be3", mem_be3, 4'b1000);
          check("vse8_b15_data3", mem_data3, 32'h4F000000);
        end
        beats++;
      end
      if (s_done) done_at = i;
      else step();
    end
    check("vse8_beats", beats, 16);
    check("vse8_done_at", done_at, 17);
    step();

    // VSSE16, negative stride, vl=5
    grp = '0;
    for (int e = 0; e < 8; e++) grp[e*16 +: 16] = 16'(16'hA000 + e);
    start_op(VLSU_VSSE16, 3'b000, 7'd5, 32'h400, 32'hFFFFFFF8, grp);
    check("vsse_b0_addr0", mem_addr0, 32'h400);
    check("vsse_b0_addr1", mem_addr1, 32'h3F8);
    check("vsse_b0_addr2", mem_addr2, 32'h3F0);
    check("vsse_b0_addr3", mem_addr3, 32'h3E8);
    check("vsse_b0_en", mem_lane_en, 4'b1111);
    check("vsse_b0_be0", mem_be0, 4'b0011);
    check("vsse_b0_data1", mem_data1, 32'h0000A001);
    step();
    check("vsse_b1_addr0", mem_addr0, 32'h3E0);
    check("vsse_b1_en", mem_lane_en, 4'b0001);
    check("vsse_b1_data0", mem_data0, 32'h0000A004);
    check("vsse_b1_be1", mem_be1, 4'b0000);
    step();
    check("vsse_done", s_done, 1);
    step();

    // Backpressure 1,0,0,1; start held and inputs changed to prove they are latched
    grp = '0;
    for (int e = 0; e < 16; e++) grp[e*32 +: 32] = 32'hC0DE0000 + 32'(e);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    mem_ready = 1'b1;
    vlsu_op = VLSU_VSE32; lmul = 3'b010; vl = 7'd16; s_base_addr = 32'h1000;
    s_stride = '0; s_data_in = grp; s_start = 1'b1;
    step();
    s_base_addr = 32'hDEAD0000; s_data_in = '0;
    accepts = 0; done_at = 0; last_acc = 0; prev_rdy = 1'b1; prev_we = 1'b0;
    prev_addr0 = '0; prev_data0 = '0; prev_en = '0;
    for (int c = 1; c <= 30 && done_at == 0; c++) begin
      if (s_done) begin
        done_at = c;
        s_start = 1'b0;
      end else begin
        if (!prev_rdy && prev_we) begin
          check("bp_hold_we", mem_we, 1);
          check("bp_hold_addr0", mem_addr0, prev_addr0);
          check("bp_hold_data0", mem_data0, prev_data0);
          check("bp_hold_en", mem_lane_en, prev_en);
        end
        mem_ready = pat[c-1];
        if (mem_we && mem_ready) begin
          check("bp_acc_addr0", mem_addr0, 32'h1000 + 32'(16 * accepts));
          check("bp_acc_data0", mem_data0, 32'hC0DE0000 + 32'(4 * accepts));
          accepts++;
          last_acc = c;
        end
        prev_rdy = mem_ready; prev_we = mem_we;
        prev_addr0 = mem_addr0; prev_data0 = mem_data0; prev_en = mem_lane_en;
        step();
      end
    end
    mem_ready = 1'b1;
    check("bp_accepts", accepts, 4);
    check("bp_done_at", done_at, 7);
    check("bp_done_after_last", done_at, last_acc + 1);
    step();
    check("bp_idle_busy", s_busy, 0);

    // vl = 0 and bad opcode: no beats, immediate done
    start_op(VLSU_VSE8, 3'b000, 7'd0, 32'h0, 32'h0, '0);
    check("vl0_done", s_done, 1);
    check("vl0_err", s_err, 0);
    check("vl0_we", mem_we, 0);
    step();
    start_op(4'hF, 3'b000, 7'd4, 32'h0, 32'h0, '0);
    check("badop_done", s_done, 1);
    check("badop_err", s_err, 1);
    check("badop_we", mem_we, 0);
    check("badop_busy", s_busy, 0);
    step();

    // Misaligned VSE32
    grp = '0;
    grp[31:0] = 32'h11111111; grp[63:32] = 32'h22222222;
    start_op(VLSU_VSE32, 3'b000, 7'd4, 32'h102, 32'h0, grp);
`ifdef VSU_MISALIGN_CHECK_EN
    check("mis_en", mem_lane_en, 4'b0000);
    check("mis_be0", mem_be0, 4'b0000);
    step();
    check("mis_done", s_done, 1);
    check("mis_err", s_err, 1);
`else
    check("mis_en", mem_lane_en, 4'b1111);
    check("mis_be0", mem_be0, 4'b1100);
    check("mis_data0", mem_data0, 32'h11110000);
    check("mis_addr1", mem_addr1, 32'h106);
    step();
    check("mis_done", s_done, 1);
    check("mis_err", s_err, 0);
`endif
    step();

    // Reset during beat 2 of 4
    start_op(VLSU_VSE32, 3'b010, 7'd16, 32'h2000, 32'h0, '0);
    step();
    check("rstmid_b1_addr0", mem_addr0, 32'h2010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_we", mem_we, 0);
    check("rstmid_busy", s_busy, 0);
    check("rstmid_en", mem_lane_en, 0);
    check("rstmid_addr0", mem_addr0, 0);
    check("rstmid_data0", mem_data0, 0);
    check("rstmid_done", s_done, 0);
    sdone_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_done) sdone_cnt++;
    end
    check("rstmid_no_done", sdone_cnt, 0);

    // vl above VLMAX is clamped; reserved lmul behaves as one register
    start_op(VLSU_VSE32, 3'b111, 7'd100, 32'h300, 32'h0, '0);
    check("clamp_en", mem_lane_en, 4'b1111);
    check("clamp_addr3", mem_addr3, 32'h30C);
    step();
    check("clamp_done", s_done, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
